// File: rtl/corr_pkg.sv
// Shared definitions for the multi-channel correlator: controller states and width helper.
package corr_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAccum,
    StDrain,
    StCompare,
    StDone
  } corr_state_e;

  // Ceiling log2; returns 0 for inputs of 0 or 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = (v > 0) ? v - 1 : 0;
    while (x != 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/corr_lane.sv
// One correlation channel: signed MAC into a wide accumulator, plus the running best-lag tracker.
module corr_lane
  import corr_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 36,
  parameter int unsigned LAG_W  = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear_i,
  input  logic                     prod_valid_i,
  input  logic                     compare_i,
  input  logic                     commit_i,
  input  logic [LAG_W-1:0]         lag_i,
  input  logic signed [DATA_W-1:0] ref_data_i,
  input  logic signed [DATA_W-1:0] oth_data_i,
  output logic [LAG_W-1:0]         best_lag_o,
  output logic signed [ACC_W-1:0]  best_sum_o
);

  localparam logic signed [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [ACC_W-1:0]    best_q, best_d;
  logic [LAG_W-1:0]           blag_q, blag_d;
  logic signed [ACC_W-1:0]    best_sum_q, best_sum_d;
  logic [LAG_W-1:0]           best_lag_q, best_lag_d;

  assign prod     = ref_data_i * oth_data_i;
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

  // Next-state: accumulate, strict-greater best update (ties keep the earlier lag), publish.
  always_comb begin
    acc_d      = acc_q;
    best_d     = best_q;
    blag_d     = blag_q;
    best_sum_d = best_sum_q;
    best_lag_d = best_lag_q;
    if (clear_i) begin
      acc_d  = '0;
      best_d = AccMin;
      blag_d = '0;
    end else if (compare_i) begin
      acc_d = '0;
      if (acc_q > best_q) begin
        best_d = acc_q;
        blag_d = lag_i;
      end
    end else if (prod_valid_i) begin
      acc_d = acc_q + prod_ext;
    end
    if (commit_i) begin
      best_sum_d = best_q;
      best_lag_d = blag_q;
    end
  end

  // Lane state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q      <= '0;
      best_q     <= '0;
      blag_q     <= '0;
      best_sum_q <= '0;
      best_lag_q <= '0;
    end else begin
      acc_q      <= acc_d;
      best_q     <= best_d;
      blag_q     <= blag_d;
      best_sum_q <= best_sum_d;
      best_lag_q <= best_lag_d;
    end
  end

  assign best_lag_o = best_lag_q;
  assign best_sum_o = best_sum_q;

endmodule

// File: rtl/multi_correlator.sv
// Correlates NUM_OTHERS channels against a reference over lags 0..2*MAX_DEV and reports the
// best lag and sum per channel. The controller walks the lags; each lane does the arithmetic.
module multi_correlator
  import corr_pkg::*;
#(
  parameter int unsigned NUM_OTHERS = 2,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned WINDOW     = 150,
  parameter int unsigned MAX_DEV    = 30,
  localparam int unsigned ADDR_W    = clog2(WINDOW + 2*MAX_DEV + 1),
  localparam int unsigned LAG_W     = clog2(2*MAX_DEV + 1),
  localparam int unsigned ACC_W     = 2*DATA_W + clog2(WINDOW + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start_i,
  input  logic                         abort_i,
  output logic [ADDR_W-1:0]            ref_addr_o,
  output logic [ADDR_W-1:0]            other_addr_o,
  input  logic [DATA_W-1:0]            ref_data_i,
  input  logic [NUM_OTHERS*DATA_W-1:0] other_data_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         result_valid_o,
  output logic [NUM_OTHERS*LAG_W-1:0]  best_lag_o,
  output logic [NUM_OTHERS*ACC_W-1:0]  best_sum_o
);

  corr_state_e       state_q, state_d;
  logic [ADDR_W-1:0] win_q, win_d;
  logic [LAG_W-1:0]  lag_q, lag_d;
  logic              pv_q, pv_d;
  logic              done_q, done_d;
  logic              rv_q, rv_d;
  logic [ADDR_W-1:0] ref_addr_q, other_addr_q;
  logic              clear, compare, commit;

  // Controller next-state and per-cycle strobes to the lanes.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    lag_d   = lag_q;
    pv_d    = 1'b0;
    done_d  = 1'b0;
    rv_d    = rv_q;
    clear   = 1'b0;
    compare = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i && !abort_i) begin
          state_d = StAccum;
          win_d   = '0;
          lag_d   = '0;
          rv_d    = 1'b0;
          clear   = 1'b1;
        end
      end
      StAccum: begin
        if (abort_i) begin
          state_d = StIdle;
        end else begin
          pv_d = 1'b1;
          if (win_q == ADDR_W'(WINDOW - 1)) begin
            state_d = StDrain;
            win_d   = '0;
          end else begin
            win_d = win_q + 1'b1;
          end
        end
      end
      StDrain: begin
        state_d = abort_i ? StIdle : StCompare;
      end
      StCompare: begin
        if (abort_i) begin
          state_d = StIdle;
        end else begin
          compare = 1'b1;
          win_d   = '0;
          if (lag_q == LAG_W'(2*MAX_DEV)) begin
            state_d = StDone;
          end else begin
            state_d = StAccum;
            lag_d   = lag_q + 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        if (!abort_i) begin
          commit = 1'b1;
          done_d = 1'b1;
          rv_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Addresses are live only in ACCUM and otherwise hold their last driven value.
  always_comb begin
    ref_addr_o   = ref_addr_q;
    other_addr_o = other_addr_q;
    if (state_q == StAccum) begin
      ref_addr_o   = win_q + ADDR_W'(MAX_DEV);
      other_addr_o = win_q + ADDR_W'(lag_q);
    end
  end

  // Controller registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      win_q        <= '0;
      lag_q        <= '0;
      pv_q         <= 1'b0;
      done_q       <= 1'b0;
      rv_q         <= 1'b0;
      ref_addr_q   <= '0;
      other_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      lag_q        <= lag_d;
      pv_q         <= pv_d;
      done_q       <= done_d;
      rv_q         <= rv_d;
      ref_addr_q   <= ref_addr_o;
      other_addr_q <= other_addr_o;
    end
  end

  assign busy_o         = (state_q != StIdle);
  assign done_o         = done_q;
  assign result_valid_o = rv_q;

  for (genvar g = 0; g < NUM_OTHERS; g++) begin : g_lane
    corr_lane #(
      .DATA_W(DATA_W),
      .ACC_W (ACC_W),
      .LAG_W (LAG_W)
    ) u_lane (
      .clk         (clk),
      .reset       (reset),
      .clear_i     (clear),
      .prod_valid_i(pv_q),
      .compare_i   (compare),
      .commit_i    (commit),
      .lag_i       (lag_q),
      .ref_data_i  (ref_data_i),
      .oth_data_i  (other_data_i[g*DATA_W +: DATA_W]),
      .best_lag_o  (best_lag_o[g*LAG_W +: LAG_W]),
      .best_sum_o  (best_sum_o[g*ACC_W +: ACC_W])
    );
  end

endmodule

// File: tb/tb_multi_correlator.sv
// Bench for multi_correlator: directed table, random runs against a lag-search model,
// and hand-written abort / reset sequences.
module tb_multi_correlator;

  localparam int NO   = 2;
  localparam int DW   = 16;
  localparam int WIN  = 8;
  localparam int MD   = 3;
  localparam int AW   = 4;
  localparam int LW   = 3;
  localparam int ACCW = 36;
  localparam int NMEM = WIN + 2*MD;
  localparam int NLAG = 2*MD + 1;
  localparam int DONE_LAT = NLAG * (WIN + 2) + 1;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start_i = 1'b0;
  logic               abort_i = 1'b0;
  logic [AW-1:0]      ref_addr_o, other_addr_o;
  logic [DW-1:0]      ref_data;
  logic [NO*DW-1:0]   other_data;
  logic               busy_o, done_o, result_valid_o;
  logic [NO*LW-1:0]   best_lag_o;
  logic [NO*ACCW-1:0] best_sum_o;

  logic signed [DW-1:0] ref_mem [NMEM];
  logic signed [DW-1:0] oth_mem [NO][NMEM];

  int     n_tests = 0;
  int     n_fail  = 0;
  int     exp_lag [NO];
  longint exp_sum [NO];

  always #5 clk = ~clk;

  multi_correlator #(
    .NUM_OTHERS(NO),
    .DATA_W    (DW),
    .WINDOW    (WIN),
    .MAX_DEV   (MD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .ref_addr_o    (ref_addr_o),
    .other_addr_o  (other_addr_o),
    .ref_data_i    (ref_data),
    .other_data_i  (other_data),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .result_valid_o(result_valid_o),
    .best_lag_o    (best_lag_o),
    .best_sum_o    (best_sum_o)
  );

  // Registered sample buffers: data appears one cycle after the address.
  always @(posedge clk) begin
    ref_data <= (int'(ref_addr_o) < NMEM) ? ref_mem[ref_addr_o] : 'x;
    for (int i = 0; i < NO; i++)
      other_data[i*DW +: DW] <= (int'(other_addr_o) < NMEM) ? oth_mem[i][other_addr_o] : 'x;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint get_sum(input int i);
    logic signed [ACCW-1:0] s;
    s = best_sum_o[i*ACCW +: ACCW];
    return longint'(s);
  endfunction

  function automatic int get_lag(input int i);
    return int'(best_lag_o[i*LW +: LW]);
  endfunction

  // Brute-force lag search straight from the definition of the correlation.
  task automatic model();
    for (int i = 0; i < NO; i++) begin
      bit have = 0;
      for (int lag = 0; lag < NLAG; lag++) begin
        longint s = 0;
        for (int w = 0; w < WIN; w++)
          s += longint'(ref_mem[w + MD]) * longint'(oth_mem[i][w + lag]);
        if (!have || s > exp_sum[i]) begin
          have = 1;
          exp_sum[i] = s;
          exp_lag[i] = lag;
        end
      end
    end
  endtask

  task automatic fill_mode(input int mode);
    int pat [8] = '{5, -3, 8, 1, -7, 4, 6, -2};
    for (int n = 0; n < NMEM; n++) begin
      ref_mem[n] = '0;
      oth_mem[0][n] = '0;
      oth_mem[1][n] = '0;
    end
    case (mode)
      0: begin
        for (int j = 0; j < 8; j++) ref_mem[j + 3] = DW'(pat[j]);
        for (int n = 0; n < NMEM; n++) begin
          oth_mem[0][n] = (n >= 2) ? ref_mem[n - 2] : '0;
          oth_mem[1][n] = (n < NMEM - 1) ? ref_mem[n + 1] : '0;
        end
      end
      1: for (int n = 0; n < NMEM; n++) begin
        ref_mem[n] = 16'sd100; oth_mem[0][n] = -16'sd100; oth_mem[1][n] = 16'sd100;
      end
      2: for (int n = 0; n < NMEM; n++) begin
        ref_mem[n] = 16'sd32767; oth_mem[0][n] = 16'sd32767; oth_mem[1][n] = 16'sh8000;
      end
      default: for (int n = 0; n < NMEM; n++) begin
        ref_mem[n] = DW'($urandom); oth_mem[0][n] = DW'($urandom); oth_mem[1][n] = DW'($urandom);
      end
    endcase
  endtask

  // Pulse start and wait (bounded) for done; returns edges from start sample to done.
  task automatic do_run(input string name, output int done_at);
    int max_addr;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk({name, "_first_ref_addr"}, ref_addr_o, MD);
    chk({name, "_first_oth_addr"}, other_addr_o, 0);
    chk({name, "_busy"}, busy_o, 1);
    chk({name, "_rv_cleared"}, result_valid_o, 0);
    done_at = -1;
    max_addr = 0;
    for (int k = 1; k <= 200 && done_at < 0; k++) begin
      step();
      if (int'(other_addr_o) > max_addr) max_addr = int'(other_addr_o);
      if (int'(ref_addr_o) > max_addr) max_addr = int'(ref_addr_o);
      if (done_o) done_at = k;
    end
    chk({name, "_done_cycle"}, done_at, DONE_LAT);
    chk({name, "_max_addr"}, max_addr, NMEM - 1);
  endtask

  typedef struct {
    string  name;
    int     mode;
    int     lag0;
    int     lag1;
    longint sum0;
    longint sum1;
  } vec_t;

  vec_t tbl [3];
  int   done_at;

  initial begin
    tbl[0] = '{name: "shift",   mode: 0, lag0: 5, lag1: 2, sum0: 204,         sum1: 204};
    tbl[1] = '{name: "neg_tie", mode: 1, lag0: 0, lag1: 0, sum0: -80000,      sum1: 80000};
    tbl[2] = '{name: "max_val", mode: 2, lag0: 0, lag1: 0, sum0: 64'sd8589410312,
               sum1: -64'sd8589672448};

    fill_mode(1);
    repeat (3) step();
    reset = 1'b0;
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_rv", result_valid_o, 0);
    chk("rst_lag", best_lag_o, 0);
    chk("rst_sum", best_sum_o != '0, 0);
    chk("rst_addr", {ref_addr_o, other_addr_o}, 0);

    foreach (tbl[t]) begin
      fill_mode(tbl[t].mode);
      do_run(tbl[t].name, done_at);
      chk({tbl[t].name, "_lag0"}, get_lag(0), tbl[t].lag0);
      chk({tbl[t].name, "_lag1"}, get_lag(1), tbl[t].lag1);
      chk({tbl[t].name, "_sum0"}, get_sum(0), tbl[t].sum0);
      chk({tbl[t].name, "_sum1"}, get_sum(1), tbl[t].sum1);
      chk({tbl[t].name, "_rv"}, result_valid_o, 1);
      step();
      chk({tbl[t].name, "_done_pulse"}, done_o, 0);
      chk({tbl[t].name, "_busy_after"}, busy_o, 0);
      chk({tbl[t].name, "_held_ref_addr"}, ref_addr_o, WIN - 1 + MD);
      chk({tbl[t].name, "_held_oth_addr"}, other_addr_o, WIN - 1 + 2*MD);
    end

    for (int r = 0; r < 4; r++) begin
      fill_mode(9);
      model();
      do_run("rand", done_at);
      for (int i = 0; i < NO; i++) begin
        chk($sformatf("rand%0d_lag%0d", r, i), get_lag(i), exp_lag[i]);
        chk($sformatf("rand%0d_sum%0d", r, i), get_sum(i), exp_sum[i]);
      end
      chk("rand_rv", result_valid_o, 1);
      step();
    end

    // Abort mid-run, with a stray start earlier that must be ignored.
    begin
      int hits = 0;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      for (int k = 1; k <= 30; k++) begin
        step();
        start_i = (k == 19);
        if (k == 25) begin
          chk("ignored_start_oth_addr", other_addr_o, (25 % (WIN + 2)) + 25 / (WIN + 2));
          chk("ignored_start_ref_addr", ref_addr_o, (25 % (WIN + 2)) + MD);
        end
        if (k == 30) abort_i = 1'b1;
      end
      step();
      abort_i = 1'b0;
      chk("abort_busy", busy_o, 0);
      for (int k = 0; k < 80; k++) begin
        step();
        if (done_o) hits++;
      end
      chk("abort_no_done", hits, 0);
      chk("abort_rv", result_valid_o, 0);
      chk("abort_busy_stays", busy_o, 0);
      for (int i = 0; i < NO; i++) begin
        chk($sformatf("abort_keep_lag%0d", i), get_lag(i), exp_lag[i]);
        chk($sformatf("abort_keep_sum%0d", i), get_sum(i), exp_sum[i]);
      end
    end

    // Start and abort together in IDLE: abort wins.
    start_i = 1'b1;
    abort_i = 1'b1;
    step();
    start_i = 1'b0;
    abort_i = 1'b0;
    chk("start_abort_idle", busy_o, 0);
    step();
    chk("start_abort_idle2", busy_o, 0);

    // Reset mid-run, then a fresh complete run.
    fill_mode(9);
    model();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int k = 1; k <= 40; k++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_busy", busy_o, 0);
    chk("midrst_rv", result_valid_o, 0);
    chk("midrst_lag", best_lag_o, 0);
    chk("midrst_sum", best_sum_o != '0, 0);
    chk("midrst_addr", {ref_addr_o, other_addr_o}, 0);
    step();
    do_run("post_rst", done_at);
    for (int i = 0; i < NO; i++) begin
      chk($sformatf("post_rst_lag%0d", i), get_lag(i), exp_lag[i]);
      chk($sformatf("post_rst_sum%0d", i), get_sum(i), exp_sum[i]);
    end
    chk("post_rst_rv", result_valid_o, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
